// File: rtl/pc_ras_unit.sv
// pc_ras_unit: IF-stage program counter with an internal circular return-address stack.
//
// Next fetch address priority, highest first: reset, trap, stall (pc_write=0),
// EX branch redirect, return, call, jump, sequential increment.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_pc_write       0 holds PC and RAS (trap still applies)
//   i_trap           exception request, loads TRAP_VECTOR and clears the RAS
//   i_branch_taken   EX-stage taken branch, redirects to i_branch_target
//   i_branch_target  EX-stage branch target
//   i_jump           unconditional jump in ID, target i_jump_addr
//   i_call           jump-and-link in ID, pushes the return address
//   i_ret            return in ID, pops the RAS
//   i_jump_addr      jump/call target
//   o_pc_out         registered fetch PC
//   o_pc_next_seq    o_pc_out + PC_STEP (combinational, wraps)
//   o_ras_count      valid RAS entries, 0..RAS_DEPTH
//   o_ras_overflow   1-cycle pulse: call while the RAS is full
//   o_ras_underflow  1-cycle pulse: ret while the RAS is empty

module pc_ras_unit #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned PC_STEP      = 1,
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0100,
  parameter int unsigned RAS_DEPTH    = 4,
  localparam int unsigned PtrW        = $clog2(RAS_DEPTH),
  localparam int unsigned CntW        = PtrW + 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pc_write,
  input  logic                i_trap,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_jump,
  input  logic                i_call,
  input  logic                i_ret,
  input  logic [PC_WIDTH-1:0] i_jump_addr,
  output logic [PC_WIDTH-1:0] o_pc_out,
  output logic [PC_WIDTH-1:0] o_pc_next_seq,
  output logic [CntW-1:0]     o_ras_count,
  output logic                o_ras_overflow,
  output logic                o_ras_underflow
);

  localparam logic [PC_WIDTH-1:0] ResetPc = RESET_VECTOR[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0] TrapPc  = TRAP_VECTOR[PC_WIDTH-1:0];
  localparam logic [CntW-1:0]     FullCnt = CntW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PtrW-1:0]     r_ptr;
  logic [CntW-1:0]     r_cnt;
  logic                r_ovf;
  logic                r_unf;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];

  logic [PC_WIDTH-1:0] w_pc_seq;
  logic [PC_WIDTH-1:0] w_pc_d;
  logic [PtrW-1:0]     w_ptr_d;
  logic [CntW-1:0]     w_cnt_d;
  logic                w_ovf_d;
  logic                w_unf_d;
  logic                w_push;

  assign w_pc_seq = r_pc + PC_WIDTH'(PC_STEP);

  always_comb begin
    w_pc_d  = r_pc;
    w_ptr_d = r_ptr;
    w_cnt_d = r_cnt;
    w_ovf_d = 1'b0;
    w_unf_d = 1'b0;
    w_push  = 1'b0;
    if (i_trap) begin
      w_pc_d  = TrapPc;
      w_ptr_d = '0;
      w_cnt_d = '0;
    end else if (!i_pc_write) begin
      // stall: hold everything, pulses stay low
    end else if (i_branch_taken) begin
      // ID is squashed, so jump/call/ret are dropped this cycle
      w_pc_d = i_branch_target;
    end else if (i_ret) begin
      if (r_cnt != '0) begin
        w_pc_d  = r_ras[r_ptr];
        w_ptr_d = r_ptr - PtrW'(1);
        w_cnt_d = r_cnt - CntW'(1);
      end else begin
        w_pc_d  = w_pc_seq;
        w_unf_d = 1'b1;
      end
    end else if (i_call) begin
      w_pc_d  = i_jump_addr;
      w_push  = 1'b1;
      w_ptr_d = r_ptr + PtrW'(1);
      // when full, the push lands on the oldest entry and count saturates
      if (r_cnt == FullCnt) begin
        w_ovf_d = 1'b1;
      end else begin
        w_cnt_d = r_cnt + CntW'(1);
      end
    end else if (i_jump) begin
      w_pc_d = i_jump_addr;
    end else begin
      w_pc_d = w_pc_seq;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc  <= ResetPc;
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_d;
      r_ptr <= w_ptr_d;
      r_cnt <= w_cnt_d;
      r_ovf <= w_ovf_d;
      r_unf <= w_unf_d;
    end
  end

  // Entry storage needs no reset; r_cnt gates every read.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      r_ras[w_ptr_d] <= w_pc_seq;
    end
  end

  assign o_pc_out        = r_pc;
  assign o_pc_next_seq   = w_pc_seq;
  assign o_ras_count     = r_cnt;
  assign o_ras_overflow  = r_ovf;
  assign o_ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_ras_unit.sv
module tb_pc_ras_unit;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] Step  = 32'd1;
  localparam logic [31:0] TrapV = 32'h100;
  localparam logic [31:0] RstV  = 32'h0;

  logic        clk;
  logic        rst, pc_write, trap, branch_taken, jump, call, ret;
  logic [31:0] branch_target, jump_addr;
  logic [31:0] pc_out, pc_next_seq;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  pc_ras_unit dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pc_write      (pc_write),
    .i_trap          (trap),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_call          (call),
    .i_ret           (ret),
    .i_jump_addr     (jump_addr),
    .o_pc_out        (pc_out),
    .o_pc_next_seq   (pc_next_seq),
    .o_ras_count     (ras_count),
    .o_ras_overflow  (ras_overflow),
    .o_ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] seq;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model: PC value plus a bounded LIFO of return addresses.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
  endfunction

  // Drive one cycle of inputs and record what the DUT must show after the next edge.
  task automatic step(input logic r, input logic pw, input logic tr, input logic br,
                      input logic [31:0] bt, input logic jp, input logic cl, input logic rt,
                      input logic [31:0] ja);
    exp_t e;
    logic [31:0] seq;
    @(negedge clk);
    rst = r; pc_write = pw; trap = tr; branch_taken = br; branch_target = bt;
    jump = jp; call = cl; ret = rt; jump_addr = ja;
    seq = m_pc + Step;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (r) begin
      m_pc = RstV; m_ras.delete();
    end else if (tr) begin
      m_pc = TrapV; m_ras.delete();
    end else if (!pw) begin
      m_pc = m_pc;
    end else if (br) begin
      m_pc = bt;
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = seq; e.unf = 1'b1; end
    end else if (cl) begin
      m_ras.push_back(seq);
      if (m_ras.size() > Depth) begin void'(m_ras.pop_front()); e.ovf = 1'b1; end
      m_pc = ja;
    end else if (jp) begin
      m_pc = ja;
    end else begin
      m_pc = seq;
    end
    e.pc  = m_pc;
    e.seq = m_pc + Step;
    e.cnt = m_ras.size();
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a new state every cycle; compare it against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("pc_next_seq", pc_next_seq, e.seq);
        chk("ras_count", {29'd0, ras_count}, e.cnt);
        chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
        chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.unf});
      end
    end
  end

  initial begin
    int wait_cyc;
    m_pc = '0;
    rst = 1; pc_write = 1; trap = 0; branch_taken = 0; branch_target = 0;
    jump = 0; call = 0; ret = 0; jump_addr = 0;

    // reset two cycles, free-run 0 -> 1,2,3
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    run(5);                                      // pc 5
    // stall three cycles, then trap while stalled
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);             // 0x100, count 0
    // branch beats jump and ret
    step(0, 1, 0, 0, 0, 1, 0, 0, 32'd10);
    step(0, 1, 0, 1, 32'h40, 1, 0, 1, 32'h80);   // 0x40
    // call/return nest
    step(0, 1, 0, 0, 0, 1, 0, 0, 32'd3);
    step(0, 1, 0, 0, 0, 0, 1, 0, 32'h20);        // 0x20, count 1
    run(1);                                      // 0x21
    step(0, 1, 0, 0, 0, 0, 1, 0, 32'h30);        // 0x30, count 2
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);             // 0x22
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);             // 4
    // overflow: five calls from pcs 1..5
    step(0, 1, 0, 0, 0, 1, 0, 0, 32'd1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 1, 0, 32'(i + 2));
    // four good rets (6,5,4,3) then underflow
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    // call+ret together with top entry 0x9
    step(0, 1, 0, 0, 0, 1, 0, 0, 32'd8);
    step(0, 1, 0, 0, 0, 0, 1, 0, 32'h50);
    step(0, 1, 0, 0, 0, 0, 1, 1, 32'h60);        // 0x9, count 0
    // reset mid-sequence, then PC wrap at the top of the address space
    step(0, 1, 0, 0, 0, 0, 1, 0, 32'h70);
    step(1, 1, 0, 0, 0, 0, 1, 0, 32'h70);
    run(1);
    step(0, 1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE); // pushes 0xFFFFFFFF+1 = 0
    run(2);                                      // 0xFFFFFFFF, 0
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);             // return to 0

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                      : 32'($urandom_range(0, 255));
      b = $urandom();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, b,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, a);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected responses left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program-counter unit for the pipelined processor, successor to the single-width word-increment PC register. It selects the next fetch address from trap, EX-stage branch redirect, return, jump/call and sequential increment. An internal circular return-address stack (RAS) serves call/return instructions. It sits at the head of the IF stage and drives the instruction-memory address.

## Interface
- PC_WIDTH, 32, width of every address port and RAS entry
- PC_STEP, 1, sequential increment; 1 = word-addressed, 4 = byte-addressed
- RESET_VECTOR, 0, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap; truncated to PC_WIDTH
- RAS_DEPTH, 4, number of RAS entries; power of two, minimum 2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_write  in  1  stall control; 0 holds the PC and RAS (trap excepted)
- trap  in  1  exception request; highest priority after reset
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  PC_WIDTH  EX-stage branch target address
- jump  in  1  unconditional jump in ID
- call  in  1  jump-and-link in ID; qualifies jump_addr and pushes the return address
- ret  in  1  return in ID; pops the RAS
- jump_addr  in  PC_WIDTH  jump/call target
- pc_out  out  PC_WIDTH  current fetch PC, registered
- pc_next_seq  out  PC_WIDTH  combinational pc_out + PC_STEP, modulo 2^PC_WIDTH
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH
- ras_overflow  out  1  registered 1-cycle pulse: push while full
- ras_underflow  out  1  registered 1-cycle pulse: pop while empty

## Operation
Priority per cycle, highest first. Only the first matching action executes.
1. rst: pc_out=RESET_VECTOR; ras_count=0; both pulses 0; RAS pointer=0.
2. trap: pc_out=TRAP_VECTOR; RAS cleared (count=0, pointer=0). Applies regardless of pc_write.
3. pc_write=0: pc_out, RAS, pointer and count hold; pulses drive 0.
4. branch_taken: pc_out=branch_target. jump/call/ret in the same cycle are ignored because ID is squashed. The RAS is not modified.
5. ret:
   - RAS non-empty: pc_out=top entry; pointer decrements; count decrements.
   - RAS empty: pc_out=pc_next_seq; ras_underflow=1; RAS unchanged.
   - call or jump asserted in the same cycle is ignored.
6. call: pc_out=jump_addr; push pc_next_seq.
   - RAS not full: count increments.
   - RAS full: the oldest entry is overwritten (circular); count stays RAS_DEPTH; ras_overflow=1.
7. jump: pc_out=jump_addr.
8. Otherwise: pc_out=pc_next_seq.

RAS rules:
- The RAS is a circular buffer of RAS_DEPTH entries. The top-of-stack pointer wraps modulo RAS_DEPTH in both directions.
- Push writes at pointer+1 and then advances the pointer. Pop reads at the pointer and then retreats it.
- Address arithmetic is unsigned and wraps modulo 2^PC_WIDTH. There is no error signal on PC wrap.
- Pulses are 0 on every cycle that is not the overflow/underflow cycle.

## Timing
- pc_out updates on the clk rising edge after the inputs are sampled, giving 1-cycle latency from any control input to the new pc_out.
- pc_next_seq is combinational from pc_out, with zero latency.
- Popped RAS data appears on pc_out on the same edge as the pop. No read latency is visible to the caller.
- ras_count, ras_overflow and ras_underflow update on the same edge as pc_out.
- A call followed by a ret on the next active cycle returns to the address pushed, including when the stack was full.
- Reset asserted mid-sequence wins on that edge. The next cycle after deassertion increments from RESET_VECTOR.

## Test plan
- Reset then free-run, PC_STEP=1: rst high 2 cycles, then low, pc_write=1 -> pc_out 0,1,2,3. Repeat with PC_STEP=4 -> 0,4,8,12.
- Stall vs trap: at pc_out=5, pc_write=0 for 3 cycles -> pc_out stays 5. Trap asserted with pc_write=0 -> pc_out=0x100 next cycle, ras_count=0.
- Branch priority: at pc_out=10, assert branch_taken (target 0x40), jump (addr 0x80) and ret together -> pc_out=0x40; ras_count unchanged.
- Call/return nest: call to 0x20 at pc 3, call to 0x30 at pc 0x21, ret, ret -> pc_out sequence 0x20,0x21,0x30,0x22,4; ras_count 1,2,1,0.
- Overflow, RAS_DEPTH=4:
  - Five calls from pcs 1,2,3,4,5 -> ras_overflow pulses on the fifth call only; ras_count=4.
  - Four rets -> return pcs 6,5,4,3.
  - Fifth ret -> ras_underflow=1; pc_out=pc_next_seq.
- Simultaneous call+ret with ras_count=1 (top entry 0x9) -> pc_out=0x9; ras_count=0; no push.
